// File: rtl/sync_lock_pkg.sv
// Shared types and constants for the VSYNC mode-lock controller.
// State codes are visible to firmware through state_o, so their encoding is fixed.
package sync_lock_pkg;

    typedef enum logic [1:0] {
        NOSYNC = 2'b00,
        ACQ    = 2'b01,
        LOCKED = 2'b10,
        HOLD   = 2'b11
    } lock_state_t;

    localparam int VT_W   = 11;
    localparam int PCNT_W = 20;
    localparam int CNT_W  = 4;

    localparam int STABLE_FRAMES_DEF = 4;
    localparam int LOST_FRAMES_DEF   = 2;
    localparam int VS_TIMEOUT_DEF    = 2700000;
    localparam int PCNT_TOL_DEF      = 16;

    // One extra bit so the subtract never wraps between unsigned frame counts.
    function automatic logic [PCNT_W:0] pcnt_abs_delta(input logic [PCNT_W-1:0] a,
                                                       input logic [PCNT_W-1:0] b);
        logic signed [PCNT_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[PCNT_W] ? $unsigned(-d) : $unsigned(d);
    endfunction

endpackage

// File: rtl/sync_lock_ctrl_if.sv
// Frontend status inputs and firmware-facing lock outputs of sync_lock_ctrl.
interface sync_lock_ctrl_if;
    import sync_lock_pkg::*;

    logic              vsync_n_i;
    logic [VT_W-1:0]   vtotal_i;
    logic              interlace_i;
    logic [PCNT_W-1:0] pcnt_frame_i;
    logic              irq_ack_i;

    logic              locked_o;
    logic              blank_o;
    logic              irq_o;
    logic [1:0]        state_o;
    logic [VT_W-1:0]   mode_vtotal_o;
    logic              mode_interlace_o;
    logic [PCNT_W-1:0] mode_pcnt_o;

    modport master (
        output vsync_n_i, vtotal_i, interlace_i, pcnt_frame_i, irq_ack_i,
        input  locked_o, blank_o, irq_o, state_o,
               mode_vtotal_o, mode_interlace_o, mode_pcnt_o
    );

    modport slave (
        input  vsync_n_i, vtotal_i, interlace_i, pcnt_frame_i, irq_ack_i,
        output locked_o, blank_o, irq_o, state_o,
               mode_vtotal_o, mode_interlace_o, mode_pcnt_o
    );

endinterface

// File: rtl/vs_edge_sync.sv
// Two-flop synchronizer plus registered falling-edge detect for active-low sync strobes.
// Shared by the VSYNC, HSYNC and FID monitors.
module vs_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_n,
    output logic evt
);

    // [0],[1] synchronize; [2] holds the previous synchronized level.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
            evt    <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], sig_n};
            evt    <= sync_q[2] & ~sync_q[1];
        end
    end

endmodule

// File: rtl/sync_lock_ctrl.sv
// Mode-lock FSM: samples frame status per VSYNC, locks after a run of matching frames,
// drops lock after a run of mismatches or a VSYNC timeout, and raises a sticky irq.
//   state  | meaning
//   NOSYNC | no valid VSYNC; next event seeds the candidate mode
//   ACQ    | counting consecutive frames matching the candidate
//   LOCKED | mode latched, frames match the locked mode
//   HOLD   | locked but recent frames mismatch; counting toward loss
module sync_lock_ctrl
    import sync_lock_pkg::*;
#(
    parameter int STABLE_FRAMES = STABLE_FRAMES_DEF,
    parameter int LOST_FRAMES   = LOST_FRAMES_DEF,
    parameter int VS_TIMEOUT    = VS_TIMEOUT_DEF,
    parameter int PCNT_TOL      = PCNT_TOL_DEF
) (
    input logic             clk27,
    input logic             reset_n,
    sync_lock_ctrl_if.slave bus
);

    localparam int                TMO_W    = $clog2(VS_TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(VS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STABLE_N = CNT_W'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0]  LOST_N   = CNT_W'(LOST_FRAMES);
    localparam logic [PCNT_W:0]   TOL_N    = (PCNT_W+1)'(PCNT_TOL);

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic              vs_evt;
    logic              cmp_en;
    logic              tmo;
    logic [TMO_W-1:0]  tmo_cnt;

    lock_state_t       state, state_nxt;
    logic [CNT_W-1:0]  stab_cnt, stab_nxt, miss_cnt, miss_nxt;
    logic              load_cand, latch_mode, irq_set, match, irq;

    logic [VT_W-1:0]   cur_vt, cand_vt, mode_vt, ref_vt;
    logic              cur_il, cand_il, mode_il, ref_il;
    logic [PCNT_W-1:0] cur_pc, cand_pc, mode_pc, ref_pc;

    // Asynchronous assert, synchronized release.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    vs_edge_sync u_vs_sync (
        .clk   (clk27),
        .rst_n (rst_n),
        .sig_n (bus.vsync_n_i),
        .evt   (vs_evt)
    );

    assign tmo = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk27 or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            cmp_en  <= 1'b0;
            cur_vt  <= '0;
            cur_il  <= 1'b0;
            cur_pc  <= '0;
        end else begin
            cmp_en <= vs_evt;
            if (vs_evt) begin
                tmo_cnt <= '0;
                cur_vt  <= bus.vtotal_i;
                cur_il  <= bus.interlace_i;
                cur_pc  <= bus.pcnt_frame_i;
            end else if (!tmo) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    // Once locked, frames are judged against the latched mode, not the candidate.
    assign ref_vt = state[1] ? mode_vt : cand_vt;
    assign ref_il = state[1] ? mode_il : cand_il;
    assign ref_pc = state[1] ? mode_pc : cand_pc;
    assign match  = (cur_vt == ref_vt) && (cur_il == ref_il) &&
                    (pcnt_abs_delta(cur_pc, ref_pc) <= TOL_N);

    always_comb begin
        state_nxt  = state;
        stab_nxt   = stab_cnt;
        miss_nxt   = miss_cnt;
        load_cand  = 1'b0;
        latch_mode = 1'b0;
        irq_set    = 1'b0;
        if (tmo) begin
            state_nxt = NOSYNC;
            irq_set   = state[1];
        end else if (cmp_en) begin
            case (state)
                NOSYNC: begin
                    load_cand = 1'b1;
                    stab_nxt  = CNT_W'(1);
                    state_nxt = ACQ;
                end
                ACQ: begin
                    if (match) begin
                        stab_nxt = stab_cnt + CNT_W'(1);
                        if (stab_nxt == STABLE_N) begin
                            state_nxt  = LOCKED;
                            latch_mode = 1'b1;
                            irq_set    = 1'b1;
                        end
                    end else begin
                        load_cand = 1'b1;
                        stab_nxt  = CNT_W'(1);
                    end
                end
                LOCKED, HOLD: begin
                    if (match) begin
                        state_nxt = LOCKED;
                        miss_nxt  = '0;
                    end else begin
                        miss_nxt  = (state == LOCKED) ? CNT_W'(1) : miss_cnt + CNT_W'(1);
                        state_nxt = HOLD;
                        if (miss_nxt == LOST_N) begin
                            state_nxt = ACQ;
                            load_cand = 1'b1;
                            stab_nxt  = CNT_W'(1);
                            irq_set   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk27 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= NOSYNC;
            stab_cnt <= '0;
            miss_cnt <= '0;
            cand_vt  <= '0;
            cand_il  <= 1'b0;
            cand_pc  <= '0;
            mode_vt  <= '0;
            mode_il  <= 1'b0;
            mode_pc  <= '0;
            irq      <= 1'b0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_nxt;
            miss_cnt <= miss_nxt;
            if (load_cand) begin
                cand_vt <= cur_vt;
                cand_il <= cur_il;
                cand_pc <= cur_pc;
            end
            if (latch_mode) begin
                mode_vt <= cand_vt;
                mode_il <= cand_il;
                mode_pc <= cand_pc;
            end
            irq <= irq_set | (irq & ~bus.irq_ack_i);
        end
    end

    assign bus.locked_o         = state[1];
    assign bus.blank_o          = ~state[1];
    assign bus.irq_o            = irq;
    assign bus.state_o          = state;
    assign bus.mode_vtotal_o    = mode_vt;
    assign bus.mode_interlace_o = mode_il;
    assign bus.mode_pcnt_o      = mode_pc;

endmodule

// File: tb/tb_sync_lock_ctrl.sv
// Bench for sync_lock_ctrl: directed lock/jitter/mode-change/loss/reset scenarios plus
// randomized frames, checked every cycle against a frame-level model of the lock rules.
module tb_sync_lock_ctrl;
    import sync_lock_pkg::*;

    localparam int SF  = 4;
    localparam int LF  = 2;
    localparam int TMO = 300;
    localparam int TOL = 16;

    localparam int S_NOSYNC = 0, S_ACQ = 1, S_LOCKED = 2, S_HOLD = 3;

    logic clk27   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk27 = ~clk27;

    sync_lock_ctrl_if bus();

    sync_lock_ctrl #(
        .STABLE_FRAMES (SF),
        .LOST_FRAMES   (LF),
        .VS_TIMEOUT    (TMO),
        .PCNT_TOL      (TOL)
    ) dut (
        .clk27   (clk27),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk27) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // Frame-level model: a decision lands 5 edges after the driven VSYNC fall
    // (3 to vs_evt, 1 to sample, 1 to decide); loss of sync lands TMO edges after the sample edge.
    typedef struct {int due; int vt; int il; int pc;} frm_t;
    frm_t evq[$];
    int   m_state, m_stab, m_miss, m_irq;
    int   c_vt, c_il, c_pc, md_vt, md_il, md_pc;
    int   last_clear;
    bit   clear_valid;
    int   ack_cyc  = -1;
    int   last_fall;

    function automatic bit same_mode(input int vt, input int il, input int pc,
                                     input int rvt, input int ril, input int rpc);
        int d;
        d = pc - rpc;
        if (d < 0) d = -d;
        return (vt == rvt) && (il == ril) && (d <= TOL);
    endfunction

    task automatic m_reset();
        evq.delete();
        m_state = S_NOSYNC; m_stab = 0; m_miss = 0; m_irq = 0;
        c_vt = 0; c_il = 0; c_pc = 0; md_vt = 0; md_il = 0; md_pc = 0;
        clear_valid = 0; last_clear = 0;
    endtask

    task automatic m_frame(input frm_t f, output bit set);
        set = 0;
        if (m_state == S_NOSYNC) begin
            c_vt = f.vt; c_il = f.il; c_pc = f.pc; m_stab = 1; m_state = S_ACQ;
        end else if (m_state == S_ACQ) begin
            if (same_mode(f.vt, f.il, f.pc, c_vt, c_il, c_pc)) begin
                m_stab++;
                if (m_stab == SF) begin
                    m_state = S_LOCKED; md_vt = c_vt; md_il = c_il; md_pc = c_pc; set = 1;
                end
            end else begin
                c_vt = f.vt; c_il = f.il; c_pc = f.pc; m_stab = 1;
            end
        end else begin
            if (same_mode(f.vt, f.il, f.pc, md_vt, md_il, md_pc)) begin
                m_state = S_LOCKED; m_miss = 0;
            end else begin
                m_miss  = (m_state == S_LOCKED) ? 1 : m_miss + 1;
                m_state = S_HOLD;
                if (m_miss == LF) begin
                    m_state = S_ACQ; c_vt = f.vt; c_il = f.il; c_pc = f.pc; m_stab = 1; set = 1;
                end
            end
        end
    endtask

    always @(negedge clk27) begin : model_chk
        bit   set, s;
        frm_t f;
        set = 0;
        if (!reset_n) begin
            m_reset();
        end else begin
            if (clear_valid && cyc == last_clear + TMO) begin
                if (m_state >= S_LOCKED) set = 1;
                m_state = S_NOSYNC;
            end
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                f = evq.pop_front();
                m_frame(f, s);
                set = set | s;
                last_clear  = cyc - 1;
                clear_valid = 1;
            end
            if (ack_cyc == cyc) m_irq = set;
            else                m_irq = m_irq | set;
        end
        chk("m_state",  32'(bus.state_o),          32'(m_state));
        chk("m_locked", 32'(bus.locked_o),         32'(m_state >= S_LOCKED));
        chk("m_blank",  32'(bus.blank_o),          32'(m_state < S_LOCKED));
        chk("m_irq",    32'(bus.irq_o),            32'(m_irq));
        chk("m_mvt",    32'(bus.mode_vtotal_o),    32'(md_vt));
        chk("m_mil",    32'(bus.mode_interlace_o), 32'(md_il));
        chk("m_mpc",    32'(bus.mode_pcnt_o),      32'(md_pc));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk27);
    endtask

    task automatic frame(input int vt, input int il, input int pc);
        @(negedge clk27);
        bus.vtotal_i     = 11'(vt);
        bus.interlace_i  = il[0];
        bus.pcnt_frame_i = 20'(pc);
        bus.vsync_n_i    = 1'b0;
        last_fall        = cyc;
        evq.push_back('{due: cyc + 5, vt: vt, il: il, pc: pc});
        @(negedge clk27);
        @(negedge clk27);
        bus.vsync_n_i = 1'b1;
    endtask

    // Called at a falling edge; the ack is sampled at the next rising edge.
    task automatic pulse_ack();
        bus.irq_ack_i = 1'b1;
        ack_cyc       = cyc + 1;
        @(negedge clk27);
        bus.irq_ack_i = 1'b0;
    endtask

    int jit[4] = '{450466, 450434, 450466, 450434};
    int mvt[3] = '{525, 625, 263};
    int mil[3] = '{0, 0, 1};
    int mpc[3] = '{450450, 540000, 225225};

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin : main
        int mi, pc, il;
        bus.vsync_n_i    = 1'b1;
        bus.vtotal_i     = '0;
        bus.interlace_i  = 1'b0;
        bus.pcnt_frame_i = '0;
        bus.irq_ack_i    = 1'b0;
        idle(3);
        chk("rst_state",  32'(bus.state_o),     32'd0);
        chk("rst_blank",  32'(bus.blank_o),     32'd1);
        chk("rst_irq",    32'(bus.irq_o),       32'd0);
        chk("rst_mpc",    32'(bus.mode_pcnt_o), 32'd0);
        @(negedge clk27); #2 reset_n = 1'b1;
        idle(6);

        // Clean acquisition, with an ack colliding with the lock irq.
        repeat (3) begin frame(525, 0, 450450); idle(20); end
        frame(525, 0, 450450);
        idle(2);
        chk("acq_pre_lock", 32'(bus.locked_o), 32'd0);
        pulse_ack();
        chk("acq_locked",   32'(bus.locked_o), 32'd1);
        chk("collide_irq",  32'(bus.irq_o),    32'd1);
        @(negedge clk27);
        pulse_ack();
        chk("lone_ack_irq", 32'(bus.irq_o),    32'd0);
        idle(20);
        repeat (2) begin frame(525, 0, 450450); idle(20); end
        chk("acq_mpc",   32'(bus.mode_pcnt_o), 32'd450450);
        chk("acq_blank", 32'(bus.blank_o),     32'd0);

        // Jitter at the tolerance edge, then one count beyond it.
        for (int i = 0; i < 4; i++) begin
            frame(525, 0, jit[i]); idle(20);
            chk("jit_state", 32'(bus.state_o), 32'd2);
            chk("jit_irq",   32'(bus.irq_o),   32'd0);
        end
        frame(525, 0, 450467); idle(20);
        chk("jit_hold",   32'(bus.state_o),  32'd3);
        chk("jit_locked", 32'(bus.locked_o), 32'd1);
        frame(525, 0, 450450); idle(20);
        chk("jit_relock", 32'(bus.state_o),  32'd2);

        // Mode change to 625 lines.
        frame(625, 0, 540000); idle(20);
        chk("mc_hold", 32'(bus.state_o), 32'd3);
        frame(625, 0, 540000); idle(20);
        chk("mc_acq",  32'(bus.state_o), 32'd1);
        chk("mc_irq",  32'(bus.irq_o),   32'd1);
        pulse_ack();
        repeat (2) begin frame(625, 0, 540000); idle(20); end
        chk("mc_still_acq", 32'(bus.state_o), 32'd1);
        frame(625, 0, 540000); idle(20);
        chk("mc_locked", 32'(bus.state_o),       32'd2);
        chk("mc_mvt",    32'(bus.mode_vtotal_o), 32'd625);
        pulse_ack();

        // Signal loss.
        frame(625, 0, 540000);
        idle(last_fall + 4 + TMO - 1 - cyc);
        chk("loss_pre",    32'(bus.state_o),  32'd2);
        @(negedge clk27);
        chk("loss_state",  32'(bus.state_o),  32'd0);
        chk("loss_locked", 32'(bus.locked_o), 32'd0);
        chk("loss_irq",    32'(bus.irq_o),    32'd1);
        pulse_ack();
        idle(5);

        // Reset in the middle of acquisition.
        repeat (2) begin frame(525, 0, 450450); idle(20); end
        chk("mid_acq", 32'(bus.state_o), 32'd1);
        @(negedge clk27); #2 reset_n = 1'b0;
        #1;
        chk("mrst_state", 32'(bus.state_o),       32'd0);
        chk("mrst_blank", 32'(bus.blank_o),       32'd1);
        chk("mrst_mvt",   32'(bus.mode_vtotal_o), 32'd0);
        chk("mrst_mpc",   32'(bus.mode_pcnt_o),   32'd0);
        idle(3);
        @(negedge clk27); #2 reset_n = 1'b1;
        idle(6);
        repeat (3) begin frame(525, 0, 450450); idle(20); end
        chk("mrst_not_yet", 32'(bus.locked_o), 32'd0);
        frame(525, 0, 450450); idle(20);
        chk("mrst_relock", 32'(bus.state_o),     32'd2);
        chk("mrst_mpc2",   32'(bus.mode_pcnt_o), 32'd450450);

        // Randomized frames around three modes, with jitter, jumps, dropouts and acks.
        mi = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) mi = int'($urandom_range(0, 2));
            pc = mpc[mi] + int'($urandom_range(0, 20)) - 10;
            if ($urandom_range(0, 5) == 0) pc = pc + int'($urandom_range(0, 60)) - 30;
            il = mil[mi];
            if ($urandom_range(0, 15) == 0) il = 1 - il;
            frame(mvt[mi], il, pc);
            if ($urandom_range(0, 19) == 0) idle(int'($urandom_range(TMO + 30, TMO + 60)));
            else                            idle(int'($urandom_range(3, 60)));
            if ($urandom_range(0, 3) == 0) pulse_ack();
        end

        idle(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
